wb_arbiter: RTL and testbench

- Writer-side front end of the integer register file: merges completed results from the ALU path and the load/store path onto the regfile's single write port (we/wd/wdata).
- Each source has its own valid/ready channel backed by a DEPTH-entry FIFO.
- Round-robin arbitration picks at most one write per cycle; the write outputs are registered.
- Exports a pending-destination bitmap so ID can detect registers whose write has not yet landed.

---
 rtl/wb_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and LSU results onto the single regfile write port.
// Each source is buffered in a DEPTH-entry FIFO; round-robin picks at most one write per cycle.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid_i,
  output logic                   alu_ready_o,
  input  logic [ADDR_W-1:0]      alu_rd_i,
  input  logic [DATA_W-1:0]      alu_data_i,
  input  logic                   lsu_valid_i,
  output logic                   lsu_ready_o,
  input  logic [ADDR_W-1:0]      lsu_rd_i,
  input  logic [DATA_W-1:0]      lsu_data_i,
  output logic                   we,
  output logic [ADDR_W-1:0]      wd,
  output logic [DATA_W-1:0]      wdata,
  output logic [(2**ADDR_W)-1:0] pend_o
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          NSRC    = 2;
  localparam logic [PW:0] PTR_INC = {{PW{1'b0}}, 1'b1};

  // Source index 0 is the ALU, index 1 is the LSU.
  logic [ADDR_W-1:0]      rd_q   [NSRC][DEPTH];
  logic [DATA_W-1:0]      data_q [NSRC][DEPTH];
  logic [PW:0]            wptr_q [NSRC];
  logic [PW:0]            rptr_q [NSRC];
  logic [PW:0]            wptr_d [NSRC];
  logic [PW:0]            rptr_d [NSRC];
  logic                   last_lsu_q;
  logic                   last_lsu_d;
  logic                   we_q;
  logic                   we_d;
  logic [ADDR_W-1:0]      wd_q;
  logic [ADDR_W-1:0]      wd_d;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      wdata_d;

  logic [NSRC-1:0]        in_valid_s;
  logic [ADDR_W-1:0]      in_rd_s   [NSRC];
  logic [DATA_W-1:0]      in_data_s [NSRC];
  logic [NSRC-1:0]        empty_s;
  logic [NSRC-1:0]        full_s;
  logic [NSRC-1:0]        push_s;
  logic [NSRC-1:0]        grant_s;
  logic                   sel_s;
  logic [ADDR_W-1:0]      head_rd_s;
  logic [DATA_W-1:0]      head_data_s;
  logic [(2**ADDR_W)-1:0] pend_s;

  assign in_valid_s   = {lsu_valid_i, alu_valid_i};
  assign in_rd_s[0]   = alu_rd_i;
  assign in_rd_s[1]   = lsu_rd_i;
  assign in_data_s[0] = alu_data_i;
  assign in_data_s[1] = lsu_data_i;

  assign alu_ready_o = !full_s[0];
  assign lsu_ready_o = !full_s[1];
  assign we          = we_q;
  assign wd          = wd_q;
  assign wdata       = wdata_q;
  assign pend_o      = pend_s;

  // FIFO occupancy flags; ready never looks at a same-cycle pop.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      empty_s[s] = (wptr_q[s] == rptr_q[s]);
      full_s[s]  = (wptr_q[s][PW] != rptr_q[s][PW]) &&
                   (wptr_q[s][PW-1:0] == rptr_q[s][PW-1:0]);
      push_s[s]  = in_valid_s[s] && !full_s[s];
    end
  end

  // Round-robin grant; the history bit only moves when both heads compete.
  always_comb begin
    grant_s    = 2'b00;
    last_lsu_d = last_lsu_q;
    if (!empty_s[0] && !empty_s[1]) begin
      if (last_lsu_q) begin
        grant_s = 2'b01;
      end else begin
        grant_s = 2'b10;
      end
      last_lsu_d = !last_lsu_q;
    end else if (!empty_s[0]) begin
      grant_s = 2'b01;
    end else if (!empty_s[1]) begin
      grant_s = 2'b10;
    end else begin
      grant_s = 2'b00;
    end
  end

  // Head of the granted FIFO and next output-register contents.
  always_comb begin
    sel_s       = grant_s[1];
    head_rd_s   = rd_q[sel_s][rptr_q[sel_s][PW-1:0]];
    head_data_s = data_q[sel_s][rptr_q[sel_s][PW-1:0]];
    we_d        = 1'b0;
    wd_d        = {ADDR_W{1'b0}};
    wdata_d     = {DATA_W{1'b0}};
    if ((grant_s != 2'b00) && (head_rd_s != {ADDR_W{1'b0}})) begin
      we_d    = 1'b1;
      wd_d    = head_rd_s;
      wdata_d = head_data_s;
    end else begin
      we_d    = 1'b0;
      wd_d    = {ADDR_W{1'b0}};
      wdata_d = {DATA_W{1'b0}};
    end
  end

  // Pointer advance: push on accepted transfer, pop only from the granted FIFO.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      wptr_d[s] = push_s[s]  ? (wptr_q[s] + PTR_INC) : wptr_q[s];
      rptr_d[s] = grant_s[s] ? (rptr_q[s] + PTR_INC) : rptr_q[s];
    end
  end

  // Pending-destination bitmap over live FIFO entries plus the output register.
  always_comb begin
    logic [PW:0]   occ_v;
    logic [PW-1:0] off_v;
    pend_s = {(2**ADDR_W){1'b0}};
    occ_v  = {(PW+1){1'b0}};
    off_v  = {PW{1'b0}};
    for (int s = 0; s < NSRC; s++) begin
      occ_v = wptr_q[s] - rptr_q[s];
      for (int i = 0; i < DEPTH; i++) begin
        off_v = PW'(i) - rptr_q[s][PW-1:0];
        if ({1'b0, off_v} < occ_v) begin
          pend_s[rd_q[s][i]] = 1'b1;
        end else begin
          pend_s = pend_s;
        end
      end
    end
    if (we_q) begin
      pend_s[wd_q] = 1'b1;
    end else begin
      pend_s = pend_s;
    end
    pend_s[0] = 1'b0;
  end

  // Control state: pointers, arbitration history and the registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NSRC; s++) begin
        wptr_q[s] <= {(PW+1){1'b0}};
        rptr_q[s] <= {(PW+1){1'b0}};
      end
      last_lsu_q <= 1'b1;
      we_q       <= 1'b0;
      wd_q       <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
      end
      last_lsu_q <= last_lsu_d;
      we_q       <= we_d;
      wd_q       <= wd_d;
      wdata_q    <= wdata_d;
    end
  end

  // FIFO storage; contents are only observed through valid pointer ranges.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (push_s[s]) begin
        rd_q[s][wptr_q[s][PW-1:0]]   <= in_rd_s[s];
        data_q[s][wptr_q[s][PW-1:0]] <= in_data_s[s];
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for the cycle-by-cycle flow,
// plus a hand-written sequence for asynchronous reset in mid-operation.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        we;
  logic [4:0]  wd;
  logic [31:0] wdata;
  logic [31:0] pend_o;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .we(we), .wd(wd), .wdata(wdata), .pend_o(pend_o)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        ewe;
    logic [4:0]  ewd;
    logic [31:0] ewdata;
    logic        eardy;
    logic        elrdy;
    logic [31:0] epend;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input int av, input int ard, input int adat,
                              input int lv, input int lrd, input int ldat,
                              input int ewe, input int ewd, input int ewdata,
                              input int eardy, input int elrdy, input int epend);
    vec_t v;
    v.av = 1'(av);   v.ard = 5'(ard);   v.adat = 32'(adat);
    v.lv = 1'(lv);   v.lrd = 5'(lrd);   v.ldat = 32'(ldat);
    v.ewe = 1'(ewe); v.ewd = 5'(ewd);   v.ewdata = 32'(ewdata);
    v.eardy = 1'(eardy); v.elrdy = 1'(elrdy); v.epend = 32'(epend);
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = adat;
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ldat;
  endtask

  task automatic check_outs(input string tag, input int idx, input logic ewe, input logic [4:0] ewd,
                            input logic [31:0] ewdata, input logic eardy, input logic elrdy,
                            input logic [31:0] epend);
    check({tag, "_we"},    idx, 32'(we),          32'(ewe));
    check({tag, "_wd"},    idx, 32'(wd),          32'(ewd));
    check({tag, "_wdata"}, idx, wdata,            ewdata);
    check({tag, "_ardy"},  idx, 32'(alu_ready_o), 32'(eardy));
    check({tag, "_lrdy"},  idx, 32'(lsu_ready_o), 32'(elrdy));
    check({tag, "_pend"},  idx, pend_o,           epend);
  endtask

  initial begin
    // Columns: alu v/rd/data, lsu v/rd/data | expected we/wd/wdata, alu_rdy, lsu_rdy, pend (after the edge)
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,   0, 0, 0,            1, 1, 32'h0000_0020));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 5, 32'hDEADBEEF, 1, 1, 32'h0000_0020));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              0, 0, 0,            1, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 1, 32'h11, 1, 2, 32'h22,    0, 0, 0,            1, 1, 32'h0000_0006));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 1, 32'h11,       1, 1, 32'h0000_0006));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 2, 32'h22,       1, 1, 32'h0000_0004));
    vecs.push_back(mk(1, 3, 32'h33, 1, 4, 32'h44,    0, 0, 0,            1, 1, 32'h0000_0018));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 4, 32'h44,       1, 1, 32'h0000_0018));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 3, 32'h33,       1, 1, 32'h0000_0008));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              0, 0, 0,            1, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,   0, 0, 0,            1, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              0, 0, 0,            1, 1, 32'h0000_0000));
    // Both channels streaming until the LSU FIFO fills; then a held LSU push while full.
    vecs.push_back(mk(1, 16, 32'hA0, 1, 8, 32'hB0,   0, 0, 0,            1, 1, 32'h0001_0100));
    vecs.push_back(mk(1, 17, 32'hA1, 1, 9, 32'hB1,   1, 16, 32'hA0,      1, 1, 32'h0003_0300));
    vecs.push_back(mk(1, 18, 32'hA2, 1, 10, 32'hB2,  1, 8, 32'hB0,       1, 1, 32'h0006_0700));
    vecs.push_back(mk(1, 19, 32'hA3, 1, 11, 32'hB3,  1, 17, 32'hA1,      1, 1, 32'h000E_0E00));
    vecs.push_back(mk(1, 20, 32'hA4, 1, 12, 32'hB4,  1, 9, 32'hB1,       1, 1, 32'h001C_1E00));
    vecs.push_back(mk(1, 21, 32'hA5, 1, 13, 32'hB5,  1, 18, 32'hA2,      1, 0, 32'h003C_3C00));
    vecs.push_back(mk(0, 0, 0, 1, 14, 32'hB6,        1, 10, 32'hB2,      1, 1, 32'h0038_3C00));
    vecs.push_back(mk(0, 0, 0, 1, 14, 32'hB6,        1, 19, 32'hA3,      1, 0, 32'h0038_7800));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 11, 32'hB3,      1, 1, 32'h0030_7800));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 20, 32'hA4,      1, 1, 32'h0030_7000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 12, 32'hB4,      1, 1, 32'h0020_7000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 21, 32'hA5,      1, 1, 32'h0020_6000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 13, 32'hB5,      1, 1, 32'h0000_6000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 14, 32'hB6,      1, 1, 32'h0000_4000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              0, 0, 0,            1, 1, 32'h0000_0000));
    vecs.push_back(mk(1, 7, 32'hA, 0, 0, 0,          0, 0, 0,            1, 1, 32'h0000_0080));
    vecs.push_back(mk(1, 7, 32'hB, 0, 0, 0,          1, 7, 32'hA,        1, 1, 32'h0000_0080));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              1, 7, 32'hB,        1, 1, 32'h0000_0080));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,              0, 0, 0,            1, 1, 32'h0000_0000));

    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst_held", 0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    #3 rst = 1'b1;
    #1;
    check_outs("rst_rel", 0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].av, vecs[k].ard, vecs[k].adat, vecs[k].lv, vecs[k].lrd, vecs[k].ldat);
      @(posedge clk);
      #1;
      check_outs("vec", k, vecs[k].ewe, vecs[k].ewd, vecs[k].ewdata,
                 vecs[k].eardy, vecs[k].elrdy, vecs[k].epend);
    end

    // Queue three entries with a write in flight, then reset between edges.
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd3, 32'h303, 1'b1, 5'd4, 32'h404);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_outs("pre_rst", 0, 1'b1, 5'd2, 32'h202, 1'b1, 1'b1, 32'h0000_001E);
    #2 rst = 1'b0;
    #1;
    check_outs("async_rst", 0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    @(posedge clk);
    #1;
    check_outs("rst_edge", 0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    #2 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_outs("post_rst", k, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
